// File: rtl/pll_lpf_pkg.sv
// Shared types and the fallback loop-filter table for the PLL power-up/relock sequencer.
package pll_lpf_pkg;

  typedef enum logic [1:0] {
    RST_HOLD,
    WAIT_LOCK,
    LOCKED,
    FAIL
  } state_e;

  typedef struct packed {
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
  } lpf_cfg_t;

  // Nominal setting first, then progressively different charge-pump/filter trade-offs.
  localparam lpf_cfg_t LPF_TABLE [0:3] = '{
    '{icpsel: 6'd16, lpfres: 3'd2, lpfcap: 2'd0},
    '{icpsel: 6'd8,  lpfres: 3'd2, lpfcap: 2'd0},
    '{icpsel: 6'd24, lpfres: 3'd3, lpfcap: 2'd1},
    '{icpsel: 6'd4,  lpfres: 3'd1, lpfcap: 2'd0}
  };

  function automatic lpf_cfg_t lpf_entry(input logic [1:0] idx);
    return LPF_TABLE[idx];
  endfunction

endpackage

// File: rtl/pll_lpf_sequencer_sync.sv
// Generic two-flop synchronizer for single-bit or multi-bit quasi-static level signals.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make both flops sample their old inputs on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lpf_sequencer.sv
// Sequences PLL reset, loop-filter selection and lock qualification; falls back through
// LPF_TABLE on lock timeout and accepts runtime filter overrides once locked or failed.
module pll_lpf_sequencer
  import pll_lpf_pkg::*;
#(
  parameter int RESET_CYCLES  = 100,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1000,
  parameter int MAX_ATTEMPTS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic [1:0] lpfcap,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_icpsel,
  input  logic [2:0] cfg_lpfres,
  input  logic [1:0] cfg_lpfcap,
  output logic       ready,
  output logic       fail,
  output logic [1:0] set_idx,
  output logic [7:0] relock_cnt
);

  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [RST_W-1:0] HOLD_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_END   = TMO_W'(LOCK_TIMEOUT);
  localparam logic [STB_W-1:0] STB_END   = STB_W'(STABLE_CYCLES);
  localparam logic [ATT_W-1:0] ATT_MAX   = ATT_W'(MAX_ATTEMPTS);

  state_e           state_q,     state_d;
  logic [RST_W-1:0] hold_q,      hold_d;
  logic [TMO_W-1:0] timer_q,     timer_d;
  logic [STB_W-1:0] stable_q,    stable_d;
  logic [ATT_W-1:0] attempt_q,   attempt_d;
  logic [1:0]       set_idx_q,   set_idx_d;
  lpf_cfg_t         cfg_q,       cfg_d;
  logic [7:0]       relock_q,    relock_d;
  logic             pll_reset_q, pll_reset_d;
  logic             ready_q,     ready_d;
  logic             fail_q,      fail_d;
  logic             lock_s;
  logic             accept;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Overrides are only taken while the PLL is not mid-sequence.
  assign accept = cfg_valid && (state_q == LOCKED || state_q == FAIL);

  // NOTE: every variable gets a hold default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    timer_d     = timer_q;
    stable_d    = stable_q;
    attempt_d   = attempt_q;
    set_idx_d   = set_idx_q;
    cfg_d       = cfg_q;
    relock_d    = relock_q;
    pll_reset_d = pll_reset_q;
    ready_d     = ready_q;
    fail_d      = fail_q;

    unique case (state_q)
      RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d     = WAIT_LOCK;
          pll_reset_d = 1'b0;
          timer_d     = '0;
          stable_d    = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        timer_d  = timer_q + 1'b1;
        stable_d = lock_s ? stable_q + 1'b1 : '0;
        // A qualified lock on the timeout cycle still counts as success.
        if (stable_d == STB_END) begin
          state_d   = LOCKED;
          ready_d   = 1'b1;
          attempt_d = '0;
        end else if (timer_d == TMO_END) begin
          attempt_d   = attempt_q + 1'b1;
          pll_reset_d = 1'b1;
          if (attempt_d == ATT_MAX) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else begin
            set_idx_d = set_idx_q + 1'b1;
            cfg_d     = lpf_entry(set_idx_d);
            state_d   = RST_HOLD;
            hold_d    = '0;
          end
        end
      end

      LOCKED, FAIL: begin
        if (state_q == LOCKED && !lock_s) begin
          relock_d    = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
          ready_d     = 1'b0;
          pll_reset_d = 1'b1;
          state_d     = RST_HOLD;
          hold_d      = '0;
        end
        if (accept) begin
          cfg_d       = {cfg_icpsel, cfg_lpfres, cfg_lpfcap};
          ready_d     = 1'b0;
          fail_d      = 1'b0;
          attempt_d   = '0;
          pll_reset_d = 1'b1;
          state_d     = RST_HOLD;
          hold_d      = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_HOLD;
      hold_q      <= '0;
      timer_q     <= '0;
      stable_q    <= '0;
      attempt_q   <= '0;
      set_idx_q   <= 2'd0;
      cfg_q       <= lpf_entry(2'd0);
      relock_q    <= 8'd0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      timer_q     <= timer_d;
      stable_q    <= stable_d;
      attempt_q   <= attempt_d;
      set_idx_q   <= set_idx_d;
      cfg_q       <= cfg_d;
      relock_q    <= relock_d;
      pll_reset_q <= pll_reset_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign cfg_ready  = accept && !reset;
  assign pll_reset  = pll_reset_q;
  assign icpsel     = cfg_q.icpsel;
  assign lpfres     = cfg_q.lpfres;
  assign lpfcap     = cfg_q.lpfcap;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign set_idx    = set_idx_q;
  assign relock_cnt = relock_q;

endmodule
